// File: rtl/vga_timing_driver_if.sv
// rtl/vga_timing_driver_if.sv - renderer request/return and VGA pin bundle
interface vga_timing_driver_if;
   logic [11:0] pixel_data;
   logic [9:0]  pixel_xpos;
   logic [9:0]  pixel_ypos;
   logic        data_req;
   logic        vga_hs;
   logic        vga_vs;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        frame_start;

   modport master (
      input  pixel_data,
      output pixel_xpos, pixel_ypos, data_req,
      output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
   );

   modport slave (
      output pixel_data,
      input  pixel_xpos, pixel_ypos, data_req,
      input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
   );
endinterface

// File: rtl/vga_timing_driver.sv
// rtl/vga_timing_driver.sv - 640x480@60Hz VGA timing generator with renderer request/return path
module vga_timing_driver #(
   parameter logic [9:0] H_SYNC  = 10'd96,
   parameter logic [9:0] H_BACK  = 10'd48,
   parameter logic [9:0] H_DISP  = 10'd640,
   parameter logic [9:0] H_FRONT = 10'd16,
   parameter logic [9:0] V_SYNC  = 10'd2,
   parameter logic [9:0] V_BACK  = 10'd33,
   parameter logic [9:0] V_DISP  = 10'd480,
   parameter logic [9:0] V_FRONT = 10'd10
) (
   input logic                 clk_25mHz,
   input logic                 rst,
   vga_timing_driver_if.master vga
);
   localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam logic [9:0] H_START = H_SYNC + H_BACK;
   localparam logic [9:0] V_START = V_SYNC + V_BACK;
   localparam logic [9:0] H_REQ_LO = H_START - 10'd1;
   localparam logic [9:0] H_REQ_HI = H_START + H_DISP - 10'd1;
   localparam logic [9:0] V_END    = V_START + V_DISP;

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] nh;
   logic [9:0] nv;
   logic       req_n;
   logic       video_en;

   always_comb begin
      nh = h_cnt + 10'd1;
      nv = v_cnt;
      if (h_cnt == H_TOTAL - 10'd1) begin
         nh = '0;
         nv = (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
      end
   end

   // Requests lead scan-out by one clock to cover the renderer's register stage
   assign req_n = (nh >= H_REQ_LO) && (nh < H_REQ_HI) && (nv >= V_START) && (nv < V_END);

   always_ff @(posedge clk_25mHz or posedge rst) begin
      if (rst) begin
         h_cnt           <= H_TOTAL - 10'd1;
         v_cnt           <= V_TOTAL - 10'd1;
         vga.vga_hs      <= 1'b1;
         vga.vga_vs      <= 1'b1;
         vga.frame_start <= 1'b0;
         vga.data_req    <= 1'b0;
         vga.pixel_xpos  <= '0;
         vga.pixel_ypos  <= '0;
         video_en        <= 1'b0;
      end else begin
         h_cnt           <= nh;
         v_cnt           <= nv;
         vga.vga_hs      <= !(nh < H_SYNC);
         vga.vga_vs      <= !(nv < V_SYNC);
         vga.frame_start <= (nh == 10'd0) && (nv == 10'd0);
         vga.data_req    <= req_n;
         vga.pixel_xpos  <= req_n ? nh - H_REQ_LO : 10'd0;
         vga.pixel_ypos  <= req_n ? nv - V_START : 10'd0;
         video_en        <= vga.data_req;
      end
   end

   // Gating keeps blanking-time garbage on pixel_data off the pins
   assign vga.vga_r = vga.pixel_data[11:8] & {4{video_en}};
   assign vga.vga_g = vga.pixel_data[7:4]  & {4{video_en}};
   assign vga.vga_b = vga.pixel_data[3:0]  & {4{video_en}};
endmodule

// File: tb/tb_vga_timing_driver.sv
// tb/tb_vga_timing_driver.sv - scoreboard bench for vga_timing_driver (vertical timing shortened)
module tb_vga_timing_driver;
   localparam int HT = 800;
   localparam int VT = 16;
   localparam int VS_LINES = 7;
   localparam int VD_LINES = 6;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        fs;
      logic        req;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rgb;
   } obs_t;

   localparam obs_t RST_EXP = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, req: 1'b0, x: 10'd0, y: 10'd0, rgb: 12'd0};

   logic clk_25mHz = 1'b0;
   logic rst = 1'b1;
   logic mode = 1'b0;
   logic [11:0] pix;
   int t = 0;
   obs_t sb[$];
   int checks = 0;
   int passed = 0;

   vga_timing_driver_if bus();

   vga_timing_driver #(
      .V_BACK(10'd5), .V_DISP(10'd6), .V_FRONT(10'd3)
   ) dut (
      .clk_25mHz(clk_25mHz),
      .rst(rst),
      .vga(bus)
   );

   always #20 clk_25mHz = ~clk_25mHz;

   // Renderer: one register stage, 12'hFFF whenever no request is outstanding
   always @(posedge clk_25mHz or posedge rst) begin
      if (rst) pix <= 12'hFFF;
      else     pix <= bus.data_req ? (mode ? {2'b00, bus.pixel_xpos} : 12'hA5C) : 12'hFFF;
   end
   assign bus.pixel_data = pix;

   function automatic obs_t expect_at(int n, logic m);
      obs_t e;
      int h, v;
      logic act_v;
      h = n % HT;
      v = (n / HT) % VT;
      act_v = (v >= VS_LINES) && (v < VS_LINES + VD_LINES);
      e.hs  = !(h < 96);
      e.vs  = !(v < 2);
      e.fs  = (h == 0) && (v == 0);
      e.req = (h >= 143) && (h < 783) && act_v;
      e.x   = e.req ? 10'(h - 143) : 10'd0;
      e.y   = e.req ? 10'(v - VS_LINES) : 10'd0;
      if ((h >= 144) && (h < 784) && act_v) e.rgb = m ? {2'b00, 10'(h - 144)} : 12'hA5C;
      else                                 e.rgb = 12'd0;
      return e;
   endfunction

   always @(posedge clk_25mHz) begin
      if (rst) begin
         sb.push_back(RST_EXP);
         t <= 0;
      end else begin
         sb.push_back(expect_at(t, mode));
         t <= t + 1;
      end
   end

   function automatic obs_t sample();
      return '{hs: bus.vga_hs, vs: bus.vga_vs, fs: bus.frame_start, req: bus.data_req,
               x: bus.pixel_xpos, y: bus.pixel_ypos, rgb: {bus.vga_r, bus.vga_g, bus.vga_b}};
   endfunction

   // Monitor: scoreboard pops plus sync/frame measurements, all counted here
   initial begin
      obs_t e, a;
      int cyc, hs_fall, vs_fall, fs_last, rgb_cnt, n_per, n_low;
      logic prev_hs, prev_vs, rst_at_neg;
      cyc = 0; hs_fall = -1; vs_fall = -1; fs_last = -1; rgb_cnt = 0; n_per = 0; n_low = 0;
      prev_hs = 1'b1; prev_vs = 1'b1;
      forever begin
         @(negedge clk_25mHz);
         rst_at_neg = rst;
         a = sample();
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (a !== e)
               $display("FAIL scoreboard cyc=%0d got hs=%b vs=%b fs=%b req=%b x=%0d y=%0d rgb=%h expected hs=%b vs=%b fs=%b req=%b x=%0d y=%0d rgb=%h",
                        cyc, a.hs, a.vs, a.fs, a.req, a.x, a.y, a.rgb, e.hs, e.vs, e.fs, e.req, e.x, e.y, e.rgb);
            else passed++;
         end
         if (rst) begin
            cyc = 0; hs_fall = -1; vs_fall = -1; fs_last = -1; rgb_cnt = 0;
            prev_hs = 1'b1; prev_vs = 1'b1;
         end else begin
            if (prev_hs && !a.hs) begin
               if (hs_fall >= 0 && n_per < 4) begin
                  n_per++; checks++;
                  if (cyc - hs_fall != HT) $display("FAIL hs_period got %0d expected %0d", cyc - hs_fall, HT);
                  else passed++;
               end
               hs_fall = cyc;
            end
            if (!prev_hs && a.hs && hs_fall >= 0 && n_low < 4) begin
               n_low++; checks++;
               if (cyc - hs_fall != 96) $display("FAIL hs_low got %0d expected 96", cyc - hs_fall);
               else passed++;
            end
            if (prev_vs && !a.vs) vs_fall = cyc;
            if (!prev_vs && a.vs && vs_fall >= 0) begin
               checks++;
               if (cyc - vs_fall != 2 * HT) $display("FAIL vs_low got %0d expected %0d", cyc - vs_fall, 2 * HT);
               else passed++;
            end
            if (a.fs) begin
               if (fs_last >= 0) begin
                  checks++;
                  if (cyc - fs_last != FRAME) $display("FAIL frame_period got %0d expected %0d", cyc - fs_last, FRAME);
                  else passed++;
                  checks++;
                  if (rgb_cnt != (mode ? 639 : 640) * VD_LINES)
                     $display("FAIL rgb_active_count got %0d expected %0d", rgb_cnt, (mode ? 639 : 640) * VD_LINES);
                  else passed++;
               end
               fs_last = cyc;
               rgb_cnt = 0;
            end
            if (a.rgb != 12'd0) rgb_cnt++;
            prev_hs = a.hs;
            prev_vs = a.vs;
            cyc++;
         end
         #3;
         if (rst && !rst_at_neg) begin
            a = sample();
            checks++;
            if (a !== RST_EXP)
               $display("FAIL async_reset got hs=%b vs=%b fs=%b req=%b x=%0d y=%0d rgb=%h expected reset values",
                        a.hs, a.vs, a.fs, a.req, a.x, a.y, a.rgb);
            else passed++;
         end
      end
   end

   initial begin
      repeat (10) @(posedge clk_25mHz);
      @(negedge clk_25mHz); #2 rst = 1'b0;
      // Stop at h=400 on active line 9 of the second frame
      repeat (FRAME + 9 * HT + 400 + 1) @(posedge clk_25mHz);
      @(negedge clk_25mHz); #2 rst = 1'b1; mode = 1'b1;
      repeat (3) @(posedge clk_25mHz);
      @(negedge clk_25mHz); #2 rst = 1'b0;
      repeat (FRAME + 2 * HT + 10) @(posedge clk_25mHz);
      @(negedge clk_25mHz);
      #5;
      checks++;
      if (sb.size() > 1) $display("FAIL scoreboard_drain got %0d expected at most 1", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
